// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_ctrl_unit_pkg;

    typedef enum logic {
        HZD_IDLE    = 1'b0,
        HZD_MC_BUSY = 1'b1
    } hzd_state_e;

    localparam int          MC_LATENCY_DEF = 4;
    localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;  // addi x0, x0, 0

    typedef struct packed {
        logic pc_we;
        logic if_id_we;
        logic if_id_flush;
        logic id_ex_we;
        logic id_ex_flush;
        logic ex_mem_bubble;
    } hzd_ctrl_t;

    localparam hzd_ctrl_t CTRL_RUN = '{
        pc_we: 1'b1, if_id_we: 1'b1, if_id_flush: 1'b0,
        id_ex_we: 1'b1, id_ex_flush: 1'b0, ex_mem_bubble: 1'b0
    };

    // Counter width for a multi-cycle op; never narrower than one bit.
    function automatic int mc_cnt_w(input int lat);
        return (lat <= 2) ? 1 : $clog2(lat);
    endfunction

endpackage

// File: rtl/hazard_ctrl_unit_mc.sv
// mc_timer: loadable down-counter with zero flag, sequencing multi-cycle EX ops.
module mc_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (load)
            cnt_q <= load_val;
        else if (dec)
            cnt_q <= cnt_q - W'(1);
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use stall, redirect flush, multi-cycle EX hold.
// Optional perf counters when HAZARD_PERF_EN is defined.
module hazard_ctrl_unit
    import hazard_ctrl_unit_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5,
`ifdef HAZARD_PERF_EN
    parameter int PERF_WIDTH     = 32,
`endif
    parameter int MC_LATENCY     = MC_LATENCY_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_ID_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_ID_i,
    input  logic                      rs1_used_ID_i,
    input  logic                      rs2_used_ID_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_EX_i,
    input  logic                      MemRead_EX_i,
    input  logic                      mc_start_EX_i,
    input  logic                      redirect_EX_i,
    output logic                      pc_we_o,
    output logic                      if_id_we_o,
    output logic                      if_id_flush_o,
    output logic                      id_ex_we_o,
    output logic                      id_ex_flush_o,
    output logic                      ex_mem_bubble_o,
    output logic                      mc_busy_o,
    output logic                      mc_done_o
`ifdef HAZARD_PERF_EN
    ,
    output logic [PERF_WIDTH-1:0]     stall_cycles_o,
    output logic [PERF_WIDTH-1:0]     flush_events_o
`endif
);

    localparam int            CW       = mc_cnt_w(MC_LATENCY);
    localparam logic          MULTI    = (MC_LATENCY > 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(MULTI ? MC_LATENCY - 2 : 0);

    hzd_state_e state_q, state_d;
    hzd_ctrl_t  ctrl;
    logic       busy, cnt_zero, start_mc, hold, load_use;

    assign busy     = (state_q == HZD_MC_BUSY);
    assign start_mc = (state_q == HZD_IDLE) && mc_start_EX_i && MULTI;
    assign hold     = start_mc || (busy && !cnt_zero);

    assign load_use = MemRead_EX_i && (rd_addr_EX_i != '0) &&
                      ((rs1_used_ID_i && (rs1_addr_ID_i == rd_addr_EX_i)) ||
                       (rs2_used_ID_i && (rs2_addr_ID_i == rd_addr_EX_i)));

    mc_timer #(.W(CW)) u_mc_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (start_mc),
        .dec      (busy && !cnt_zero),
        .load_val (LOAD_VAL),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= HZD_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            HZD_IDLE:    if (start_mc) state_d = HZD_MC_BUSY;
            HZD_MC_BUSY: if (cnt_zero) state_d = HZD_IDLE;
            default:     state_d = HZD_IDLE;
        endcase
    end

    // Hold outranks redirect (EX still owns the MC op), redirect outranks load-use.
    always_comb begin
        ctrl = CTRL_RUN;
        if (hold) begin
            ctrl.pc_we         = 1'b0;
            ctrl.if_id_we      = 1'b0;
            ctrl.id_ex_we      = 1'b0;
            ctrl.ex_mem_bubble = 1'b1;
        end else if (redirect_EX_i) begin
            ctrl.if_id_flush   = 1'b1;
            ctrl.id_ex_flush   = 1'b1;
        end else if (load_use) begin
            ctrl.pc_we         = 1'b0;
            ctrl.if_id_we      = 1'b0;
            ctrl.id_ex_flush   = 1'b1;
        end
    end

    assign pc_we_o         = ctrl.pc_we;
    assign if_id_we_o      = ctrl.if_id_we;
    assign if_id_flush_o   = ctrl.if_id_flush;
    assign id_ex_we_o      = ctrl.id_ex_we;
    assign id_ex_flush_o   = ctrl.id_ex_flush;
    assign ex_mem_bubble_o = ctrl.ex_mem_bubble;
    assign mc_busy_o       = busy;
    assign mc_done_o       = busy && cnt_zero;

`ifdef HAZARD_PERF_EN
    logic [PERF_WIDTH-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!ctrl.pc_we)      stall_cnt_q <= stall_cnt_q + PERF_WIDTH'(1);
            if (ctrl.if_id_flush) flush_cnt_q <= flush_cnt_q + PERF_WIDTH'(1);
        end
    end

    assign stall_cycles_o = stall_cnt_q;
    assign flush_events_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit: directed scenarios plus randomized traffic
// against an occupancy-based reference model.
module tb_hazard_ctrl_unit;

    localparam int LAT = 4;

    // Packed output view: {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, bubble, busy, done}
    localparam logic [7:0] O_RUN   = 8'b1101_0000;
    localparam logic [7:0] O_LU    = 8'b0001_1000;
    localparam logic [7:0] O_REDIR = 8'b1111_1000;
    localparam logic [7:0] O_HOLD0 = 8'b0000_0100;
    localparam logic [7:0] O_HOLDB = 8'b0000_0110;
    localparam logic [7:0] O_DONE  = 8'b1101_0011;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs1, rs2, rd;
    logic       rs1_used, rs2_used, mem_rd, mc_start, redir;
    logic       pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, bubble, busy, done;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles, flush_events;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int mc_left;   // remaining EX cycles of the current multi-cycle op, 0 = none

    hazard_ctrl_unit #(.REG_ADDR_WIDTH(5), .MC_LATENCY(LAT)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rs1_addr_ID_i   (rs1),
        .rs2_addr_ID_i   (rs2),
        .rs1_used_ID_i   (rs1_used),
        .rs2_used_ID_i   (rs2_used),
        .rd_addr_EX_i    (rd),
        .MemRead_EX_i    (mem_rd),
        .mc_start_EX_i   (mc_start),
        .redirect_EX_i   (redir),
        .pc_we_o         (pc_we),
        .if_id_we_o      (if_id_we),
        .if_id_flush_o   (if_id_flush),
        .id_ex_we_o      (id_ex_we),
        .id_ex_flush_o   (id_ex_flush),
        .ex_mem_bubble_o (bubble),
        .mc_busy_o       (busy),
        .mc_done_o       (done)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cycles_o  (stall_cycles),
        .flush_events_o  (flush_events)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] dut_out();
        return {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, bubble, busy, done};
    endfunction

    function automatic int occupancy();
        int occ = mc_left;
        if (occ == 0 && mc_start && LAT > 1) occ = LAT;
        return occ;
    endfunction

    // Expected outputs from the architectural rules, given model occupancy and current inputs.
    function automatic logic [7:0] ref_out();
        int   occ = occupancy();
        logic in_op = (occ > 0);
        logic hld = (occ > 1);
        logic lu  = mem_rd && rd != 0 && ((rs1_used && rs1 == rd) || (rs2_used && rs2 == rd));
        logic [7:0] e;
        if (hld)        e = 8'b0000_0100;
        else if (redir) e = O_REDIR;
        else if (lu)    e = O_LU;
        else            e = O_RUN;
        e[1] = in_op && (occ < LAT);
        e[0] = in_op && (occ == 1);
        return e;
    endfunction

    task automatic set_in(input logic [4:0] a1, input logic u1, input logic [4:0] a2, input logic u2,
                          input logic [4:0] d, input logic mr, input logic ms, input logic rx);
        rs1 = a1; rs1_used = u1; rs2 = a2; rs2_used = u2;
        rd = d; mem_rd = mr; mc_start = ms; redir = rx;
    endtask

    task automatic tick();
        int occ = occupancy();
        mc_left = (occ > 0) ? occ - 1 : 0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        mc_left = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #3;
        n_chk++;
        if (dut_out() !== O_RUN) begin
            n_fail++; $display("FAIL reset_state: got %b expected %b", dut_out(), O_RUN);
        end
        do_reset();
        @(negedge clk);
        n_chk++;
        if (dut_out() !== O_RUN) begin
            n_fail++; $display("FAIL after_reset: got %b expected %b", dut_out(), O_RUN);
        end
        tick();
    endtask

    task automatic test_load_use();
        set_in(5, 1, 1, 1, 5, 1, 0, 0);       // lw x5 ; add x6,x5,x1
        @(negedge clk);
        n_chk++;
        if (dut_out() !== O_LU) begin
            n_fail++; $display("FAIL load_use_rs1: got %b expected %b", dut_out(), O_LU);
        end
        tick();
        set_in(5, 1, 1, 1, 0, 0, 0, 0);       // bubble now in EX
        @(negedge clk);
        n_chk++;
        if (dut_out() !== O_RUN) begin
            n_fail++; $display("FAIL load_use_release: got %b expected %b", dut_out(), O_RUN);
        end
        tick();
        set_in(2, 1, 9, 1, 9, 1, 0, 0);       // match on rs2 only
        @(negedge clk);
        n_chk++;
        if (dut_out() !== O_LU) begin
            n_fail++; $display("FAIL load_use_rs2: got %b expected %b", dut_out(), O_LU);
        end
        tick();
    endtask

    task automatic test_no_stall();
        set_in(0, 1, 0, 1, 0, 1, 0, 0);       // load to x0
        @(negedge clk);
        n_chk++;
        if (dut_out() !== O_RUN) begin
            n_fail++; $display("FAIL no_stall_x0: got %b expected %b", dut_out(), O_RUN);
        end
        tick();
        set_in(5, 0, 1, 1, 5, 1, 0, 0);       // rs1 matches but not read
        @(negedge clk);
        n_chk++;
        if (dut_out() !== O_RUN) begin
            n_fail++; $display("FAIL no_stall_unused: got %b expected %b", dut_out(), O_RUN);
        end
        tick();
        set_in(5, 1, 5, 1, 5, 0, 0, 0);       // same rd but EX is not a load
        @(negedge clk);
        n_chk++;
        if (dut_out() !== O_RUN) begin
            n_fail++; $display("FAIL no_stall_noload: got %b expected %b", dut_out(), O_RUN);
        end
        tick();
    endtask

    task automatic test_multicycle();
        logic [7:0] exp_seq [5] = '{O_HOLD0, O_HOLDB, O_HOLDB, O_DONE, O_RUN};
        for (int c = 0; c < 5; c++) begin
            set_in(0, 0, 0, 0, 0, 0, (c < 4), 0);
            if (c == 1) set_in(7, 1, 0, 0, 7, 1, 1, 0);   // load-use masked by hold
            if (c == 2) set_in(0, 0, 0, 0, 0, 0, 1, 1);   // stray redirect ignored
            @(negedge clk);
            n_chk++;
            if (dut_out() !== exp_seq[c]) begin
                n_fail++; $display("FAIL mc_cycle%0d: got %b expected %b", c + 1, dut_out(), exp_seq[c]);
            end
            tick();
        end
    endtask

    task automatic test_redirect_priority();
        set_in(5, 1, 0, 0, 5, 1, 0, 1);
        @(negedge clk);
        n_chk++;
        if (dut_out() !== O_REDIR) begin
            n_fail++; $display("FAIL redirect_over_lu: got %b expected %b", dut_out(), O_REDIR);
        end
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_chk++;
        if (dut_out() !== O_RUN) begin
            n_fail++; $display("FAIL redirect_next: got %b expected %b", dut_out(), O_RUN);
        end
        tick();
    endtask

    task automatic test_reset_mid_op();
        logic saw_done = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        tick();                                // now MC_BUSY cycle 2
        #2;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        mc_left = 0;
        #1;
        n_chk++;
        if (dut_out() !== O_RUN) begin
            n_fail++; $display("FAIL reset_mid_op: got %b expected %b", dut_out(), O_RUN);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
            tick();
        end
        n_chk++;
        if (saw_done !== 1'b0) begin
            n_fail++; $display("FAIL reset_no_done: got %b expected %b", saw_done, 1'b0);
        end
        for (int c = 0; c < 5; c++) begin
            set_in(0, 0, 0, 0, 0, 0, (c < 4), 0);
            @(negedge clk);
            n_chk++;
            if (dut_out() !== ref_out()) begin
                n_fail++; $display("FAIL post_reset_mc%0d: got %b expected %b", c + 1, dut_out(), ref_out());
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            set_in(5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0),
                   ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
            @(negedge clk);
            n_chk++;
            if (dut_out() !== ref_out()) begin
                n_fail++; $display("FAIL random_c%0d: got %b expected %b", c, dut_out(), ref_out());
            end
            tick();
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (LAT) tick();
    endtask

`ifdef HAZARD_PERF_EN
    task automatic test_perf();
        do_reset();
        set_in(5, 1, 1, 1, 5, 1, 0, 0); tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0); tick();
        for (int c = 0; c < 4; c++) begin
            set_in(0, 0, 0, 0, 0, 0, 1, 0); tick();
        end
        set_in(5, 1, 0, 0, 5, 1, 0, 1); tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0); tick();
        n_chk++;
        if (stall_cycles !== 32'd4) begin
            n_fail++; $display("FAIL perf_stalls: got %0d expected 4", stall_cycles);
        end
        n_chk++;
        if (flush_events !== 32'd1) begin
            n_fail++; $display("FAIL perf_flushes: got %0d expected 1", flush_events);
        end
        force dut.stall_cnt_q = '1;
        #1;
        release dut.stall_cnt_q;
        set_in(5, 1, 1, 1, 5, 1, 0, 0); tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        n_chk++;
        if (stall_cycles !== 32'd0) begin
            n_fail++; $display("FAIL perf_wrap: got %0d expected 0", stall_cycles);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        mc_left = 0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_load_use();
        test_no_stall();
        test_multicycle();
        test_redirect_priority();
        test_reset_mid_op();
        test_random();
`ifdef HAZARD_PERF_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
